shift_result_select_q: RTL and testbench

- Downstream consumer of the constant-shift stage: takes its three 8-bit results (logical left, logical right, arithmetic right) plus a per-transaction op code.
- Selects one result, tags it with a zero flag, and buffers it in a small FIFO with a valid/ready output handshake.
- Decouples the combinational shifter from a stalling consumer; tracks illegal ops and accepted-transaction count for debug.

---
 rtl/shift_result_select_q.sv | 117 +++++++++++
 tb/tb_shift_result_select_q.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_result_select_q.sv
// Result selector for the constant-shift stage: picks one of three shifted values per op,
// tags it with a zero flag and queues it in a small FIFO behind a valid/ready handshake.
module shift_result_select_q #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 shl_c,
    input  logic [7:0]                 shr_c,
    input  logic [7:0]                 ashr_c,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic [1:0]                 out_op,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       illegal_seen,
    input  logic                       clr_sticky,
    output logic [CNT_W-1:0]           acc_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        OP_SHL  = 2'd0,
        OP_SHR  = 2'd1,
        OP_ASHR = 2'd2,
        OP_ILL  = 2'd3
    } op_e;

    logic [7:0]    r_mem_data [DEPTH];
    logic [1:0]    r_mem_op   [DEPTH];
    logic          r_mem_zero [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_illegal;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_sel;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_accept  = in_valid && !w_full;
    assign w_illegal = w_accept && (op_e'(op) == OP_ILL);
    assign w_push    = w_accept && (op_e'(op) != OP_ILL);
    assign w_pop     = !w_empty && out_ready;

    always_comb begin
        w_sel = '0;
        case (op_e'(op))
            OP_SHL:  w_sel = shl_c;
            OP_SHR:  w_sel = shr_c;
            OP_ASHR: w_sel = ashr_c;
            default: w_sel = '0;
        endcase
    end

    // Storage has no reset; stale slots are never visible because out_* are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_sel;
            r_mem_op[r_wptr]   <= op;
            r_mem_zero[r_wptr] <= (w_sel == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A new illegal accept takes priority over a concurrent clear.
            if (w_illegal) begin
                r_illegal <= 1'b1;
            end else if (clr_sticky) begin
                r_illegal <= 1'b0;
            end
        end
    end

    assign in_ready     = !w_full;
    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? '0 : r_mem_data[r_rptr];
    assign out_op       = w_empty ? '0 : r_mem_op[r_rptr];
    assign out_zero     = w_empty ? 1'b0 : r_mem_zero[r_rptr];
    assign level        = r_level;
    assign illegal_seen = r_illegal;
    assign acc_cnt      = r_cnt;

endmodule

// File: tb/tb_shift_result_select_q.sv
// Bench for shift_result_select_q: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_shift_result_select_q;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] shl_c = '0;
    logic [7:0] shr_c = '0;
    logic [7:0] ashr_c = '0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_op;
    logic       out_zero;
    logic [2:0] level;
    logic       illegal_seen;
    logic       clr_sticky = 1'b0;
    logic [CNT_W-1:0] acc_cnt;

    shift_result_select_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .shl_c(shl_c), .shr_c(shr_c), .ashr_c(ashr_c), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_op(out_op), .out_zero(out_zero), .level(level),
        .illegal_seen(illegal_seen), .clr_sticky(clr_sticky), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] op;
    } entry_t;

    entry_t q[$];
    bit     m_sticky;
    int     m_cnt;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit has = (q.size() > 0);
        check("level",     32'(level),        32'(q.size()));
        check("out_valid", 32'(out_valid),    32'(has));
        check("in_ready",  32'(in_ready),     32'(q.size() < DEPTH));
        check("out_data",  32'(out_data),     has ? 32'(q[0].data) : 32'd0);
        check("out_op",    32'(out_op),       has ? 32'(q[0].op) : 32'd0);
        check("out_zero",  32'(out_zero),     32'(has && q[0].data == 8'd0));
        check("illegal",   32'(illegal_seen), 32'(m_sticky));
        check("acc_cnt",   32'(acc_cnt),      32'(m_cnt));
    endtask

    // Applies one cycle of stimulus, advances the model across the edge, then compares.
    task automatic step(input logic r, input logic iv, input logic [1:0] o,
                        input logic [7:0] sl, input logic [7:0] sr, input logic [7:0] sa,
                        input logic ordy, input logic clr);
        bit acc, pop;
        entry_t e;
        rst = r; in_valid = iv; op = o; shl_c = sl; shr_c = sr; ashr_c = sa;
        out_ready = ordy; clr_sticky = clr;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_sticky = 0;
            m_cnt = 0;
        end else begin
            acc = iv && (q.size() < DEPTH);
            pop = (q.size() > 0) && ordy;
            if (pop) void'(q.pop_front());
            if (acc && o == 2'd3) begin
                m_sticky = 1;
            end else begin
                if (clr) m_sticky = 0;
                if (acc) begin
                    e.op = o;
                    e.data = (o == 2'd0) ? sl : (o == 2'd1) ? sr : sa;
                    q.push_back(e);
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, ordy, 0);
    endtask

    initial begin
        m_sticky = 0;
        m_cnt = 0;
        step(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        step(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 0);

        // single transfer
        step(0, 1, 2'd0, 8'hA4, 8'h11, 8'h22, 1, 0);
        check("first_data", 32'(out_data), 32'h0000_00A4);
        idle(1);
        check("first_cnt", 32'(acc_cnt), 32'd1);

        // fill to full, fifth beat refused
        step(0, 1, 2'd1, 8'h33, 8'h0F, 8'h44, 0, 0);
        step(0, 1, 2'd2, 8'h55, 8'h66, 8'hF0, 0, 0);
        step(0, 1, 2'd0, 8'h00, 8'h77, 8'h88, 0, 0);
        step(0, 1, 2'd1, 8'h99, 8'h01, 8'hAA, 0, 0);
        check("full_level", 32'(level), 32'd4);
        step(0, 1, 2'd0, 8'h5A, 8'h5B, 8'h5C, 0, 0);
        check("full_refuse", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) idle(1);

        // concurrent push/pop at level 2
        step(0, 1, 2'd0, 8'h10, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h20, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'(i % 3), 8'h30 + 8'(i), 8'h40 + 8'(i), 8'h50 + 8'(i), 1, 0);
            check("pp_level", 32'(level), 32'd2);
        end
        idle(1); idle(1);

        // illegal op sticky
        step(0, 1, 2'd3, 8'h01, 8'h02, 8'h03, 1, 0);
        step(0, 1, 2'd3, 8'h01, 8'h02, 8'h03, 1, 1);
        check("sticky_set_wins", 32'(illegal_seen), 32'd1);
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1, 1);
        check("sticky_clr", 32'(illegal_seen), 32'd0);

        // reset with entries queued
        for (int i = 0; i < 3; i++) step(0, 1, 2'd2, 8'h00, 8'h00, 8'hC0 + 8'(i), 0, 0);
        step(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        check("rst_level", 32'(level), 32'd0);
        step(0, 1, 2'd1, 8'h00, 8'hE7, 8'h00, 0, 0);
        step(0, 1, 2'd0, 8'h3C, 8'h00, 8'h00, 1, 0);
        idle(1); idle(1);

        // counter wrap at CNT_W=4
        step(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 2'(i % 3), 8'(i), 8'(i + 1), 8'(i + 2), 1, 0);
        check("cnt_wrap", 32'(acc_cnt), 32'd1);

        // random traffic with phase-varying consumer pressure
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a, b, c;
            int rdy_pct = ((i / 50) % 2 == 0) ? 30 : 85;
            a = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            c = 8'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
                 a, b, c, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
